// File: rtl/req_dispatch_pkg.sv
// Shared definitions for the request dispatcher: sizes, FSM encoding and the
// code-to-mask helper used to clear a pending bit once its grant is taken.
package req_dispatch_pkg;

   localparam int N_REQ  = 12;
   localparam int CODE_W = 4;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT1 = 2'd1,
      GNT2 = 2'd2
   } state_t;

   localparam logic [CODE_W-1:0] CODE_NONE = '0;
   localparam logic [CODE_W-1:0] CODE_MAX  = CODE_W'(N_REQ);

   // A code k selects pending bit k-1; code 0 and codes above N_REQ select nothing.
   function automatic logic [N_REQ-1:0] code2onehot(input logic [CODE_W-1:0] code);
      logic [N_REQ-1:0] mask;
      mask = '0;
      for (int i = 0; i < N_REQ; i++) begin
         mask[i] = (int'(code) == i + 1);
      end
      return mask;
   endfunction

endpackage

// File: rtl/req_dispatch_if.sv
// Bundle of everything the dispatcher exchanges with its neighbours: request
// strobes in, pending vector out to the encoder, codes back, and the grant port.
interface req_dispatch_if;
   import req_dispatch_pkg::*;

   logic [N_REQ-1:0]  req_in;
   logic [N_REQ-1:0]  pend_o;
   logic [CODE_W-1:0] first_i;
   logic [CODE_W-1:0] second_i;
   logic              gnt_valid;
   logic [CODE_W-1:0] gnt_code;
   logic              gnt_ready;
   logic              busy;
   logic              code_err;
   logic [CNT_W-1:0]  gnt_cnt;

   modport master (
      input  req_in, first_i, second_i, gnt_ready,
      output pend_o, gnt_valid, gnt_code, busy, code_err, gnt_cnt
   );

   modport slave (
      output req_in, first_i, second_i, gnt_ready,
      input  pend_o, gnt_valid, gnt_code, busy, code_err, gnt_cnt
   );

endinterface

// File: rtl/req_pend_reg.sv
// Sticky pending vector. A set and a clear of the same bit in one cycle keeps
// the bit, so a request arriving as its previous grant is taken is not lost.
module req_pend_reg
   import req_dispatch_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] i_set,
   input  logic [N_REQ-1:0] i_clr,
   output logic [N_REQ-1:0] o_pend
);

   logic [N_REQ-1:0] r_pend;

   // Clear accepted bits first, then OR in new requests so set has priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend <= '0;
      end else begin
         r_pend <= (r_pend & ~i_clr) | i_set;
      end
   end

   assign o_pend = r_pend;

endmodule

// File: rtl/req_dispatch.sv
// Request dispatcher: feeds the pending vector to the dual priority encoder,
// snapshots its two codes and offers them as up to two grants per scan.
module req_dispatch
   import req_dispatch_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   req_dispatch_if.master bus
);

   state_t            r_state;
   logic [CODE_W-1:0] r_c2;
   logic [CODE_W-1:0] r_gntCode;
   logic              r_gntValid;
   logic              r_busy;
   logic              r_codeErr;
   logic [CNT_W-1:0]  r_gntCnt;

   logic              w_accept;
   logic              w_firstBad;
   logic              w_secondBad;
   logic [N_REQ-1:0]  w_clrMask;
   logic [N_REQ-1:0]  w_pend;

   assign w_accept    = r_gntValid & bus.gnt_ready;
   assign w_clrMask   = w_accept ? code2onehot(r_gntCode) : '0;
   assign w_firstBad  = (bus.first_i == CODE_NONE) || (bus.first_i > CODE_MAX);
   assign w_secondBad = (bus.second_i > CODE_MAX);

   req_pend_reg u_pend (
      .clk    (clk),
      .reset  (reset),
      .i_set  (bus.req_in),
      .i_clr  (w_clrMask),
      .o_pend (w_pend)
   );

   // Scan/grant sequencer; r_gntCode carries the first code through GNT1 and
   // is reloaded with the snapshotted second code on the way into GNT2.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_c2       <= CODE_NONE;
         r_gntCode  <= CODE_NONE;
         r_gntValid <= 1'b0;
         r_busy     <= 1'b0;
         r_codeErr  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pend != '0) begin
                  if (w_firstBad) begin
                     r_codeErr <= 1'b1;
                  end else begin
                     if (w_secondBad || (bus.second_i == bus.first_i)) begin
                        r_c2 <= CODE_NONE;
                     end else begin
                        r_c2 <= bus.second_i;
                     end
                     if (w_secondBad) begin
                        r_codeErr <= 1'b1;
                     end
                     r_state    <= GNT1;
                     r_gntCode  <= bus.first_i;
                     r_gntValid <= 1'b1;
                     r_busy     <= 1'b1;
                  end
               end
            end
            GNT1: begin
               if (bus.gnt_ready) begin
                  if (r_c2 != CODE_NONE) begin
                     r_state   <= GNT2;
                     r_gntCode <= r_c2;
                  end else begin
                     r_state    <= IDLE;
                     r_gntCode  <= CODE_NONE;
                     r_gntValid <= 1'b0;
                     r_busy     <= 1'b0;
                  end
               end
            end
            GNT2: begin
               if (bus.gnt_ready) begin
                  r_state    <= IDLE;
                  r_c2       <= CODE_NONE;
                  r_gntCode  <= CODE_NONE;
                  r_gntValid <= 1'b0;
                  r_busy     <= 1'b0;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_gntCode  <= CODE_NONE;
               r_gntValid <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   // Count every accepted grant; wraps silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_gntCnt <= '0;
      end else if (w_accept) begin
         r_gntCnt <= r_gntCnt + 1'b1;
      end
   end

   assign bus.pend_o    = w_pend;
   assign bus.gnt_valid = r_gntValid;
   assign bus.gnt_code  = r_gntCode;
   assign bus.busy      = r_busy;
   assign bus.code_err  = r_codeErr;
   assign bus.gnt_cnt   = r_gntCnt;

endmodule

// File: tb/tb_req_dispatch.sv
// Bench for req_dispatch: behavioural dual priority encoder, directed scenarios
// and a randomized run scored against a set-based pending/grant model.
module tb_req_dispatch;
   import req_dispatch_pkg::*;

   logic clk = 1'b0;
   logic reset;

   int total = 0;
   int bad   = 0;

   logic       forceCodes;
   logic [3:0] forceFirst;
   logic [3:0] forceSecond;

   logic [11:0] modelPend;
   logic [7:0]  modelCnt;
   logic        preValid;
   logic        preReady;
   logic [3:0]  preCode;
   logic [11:0] prePend;
   logic [3:0]  expSecond;
   int          phase;

   req_dispatch_if bus();

   req_dispatch dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Code of the n-th lowest set bit (bit index + 1), or 0 if there is none.
   function automatic logic [3:0] nthCode(input logic [11:0] v, input int n);
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (v[i]) begin
            if (seen == n) return 4'(i + 1);
            seen++;
         end
      end
      return 4'd0;
   endfunction

   // Encoder stand-in: lowest two pending bits, unless the bench forces codes.
   always_comb begin
      bus.first_i  = nthCode(bus.pend_o, 0);
      bus.second_i = nthCode(bus.pend_o, 1);
      if (forceCodes) begin
         bus.first_i  = forceFirst;
         bus.second_i = forceSecond;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One random cycle: drive inputs, note what was offered, clock, then advance the model.
   task automatic applyStimulus(input logic [11:0] reqVec, input logic ready);
      logic [11:0] mask;
      bus.req_in    = reqVec;
      bus.gnt_ready = ready;
      preValid = bus.gnt_valid;
      preCode  = bus.gnt_code;
      preReady = ready;
      prePend  = modelPend;
      tick();
      mask = 12'd0;
      if (preValid && preReady) begin
         if (preCode >= 4'd1 && preCode <= 4'd12) mask = 12'(1 << (int'(preCode) - 1));
         modelCnt = modelCnt + 8'd1;
      end
      modelPend = (modelPend & ~mask) | reqVec;
   endtask

   task automatic checkOutput();
      expectEq("rndPend", 32'(bus.pend_o), 32'(modelPend));
      expectEq("rndCnt", 32'(bus.gnt_cnt), 32'(modelCnt));
      expectEq("rndBusy", 32'(bus.busy), 32'(bus.gnt_valid));
      expectEq("rndErr", 32'(bus.code_err), 32'd0);
      if (!bus.gnt_valid) expectEq("rndIdleCode", 32'(bus.gnt_code), 32'd0);
      if (preValid && !preReady) begin
         expectEq("rndHoldValid", 32'(bus.gnt_valid), 32'd1);
         expectEq("rndHoldCode", 32'(bus.gnt_code), 32'(preCode));
      end else if (!preValid) begin
         expectEq("rndScan", 32'(bus.gnt_valid), 32'(prePend != 12'd0));
         if (bus.gnt_valid) begin
            expectEq("rndFirst", 32'(bus.gnt_code), 32'(nthCode(prePend, 0)));
            expSecond = nthCode(prePend, 1);
            phase = 1;
         end
      end else if (phase == 1) begin
         expectEq("rndSecondValid", 32'(bus.gnt_valid), 32'(expSecond != 4'd0));
         if (expSecond != 4'd0) begin
            expectEq("rndSecond", 32'(bus.gnt_code), 32'(expSecond));
            phase = 2;
         end else begin
            phase = 0;
         end
      end else begin
         expectEq("rndEndValid", 32'(bus.gnt_valid), 32'd0);
         phase = 0;
      end
   endtask

   initial begin
      reset       = 1'b1;
      bus.req_in  = 12'h000;
      bus.gnt_ready = 1'b0;
      forceCodes  = 1'b0;
      forceFirst  = 4'd0;
      forceSecond = 4'd0;
      tick();
      tick();
      expectEq("rstValid", 32'(bus.gnt_valid), 32'd0);
      expectEq("rstCode", 32'(bus.gnt_code), 32'd0);
      expectEq("rstPend", 32'(bus.pend_o), 32'd0);
      expectEq("rstBusy", 32'(bus.busy), 32'd0);
      expectEq("rstErr", 32'(bus.code_err), 32'd0);
      expectEq("rstCnt", 32'(bus.gnt_cnt), 32'd0);
      reset = 1'b0;
      tick();

      $display("[TB] single request");
      bus.gnt_ready = 1'b1;
      bus.req_in = 12'h001;
      tick();
      bus.req_in = 12'h000;
      expectEq("t2PendSet", 32'(bus.pend_o), 32'h001);
      expectEq("t2NotYet", 32'(bus.gnt_valid), 32'd0);
      tick();
      expectEq("t2Valid", 32'(bus.gnt_valid), 32'd1);
      expectEq("t2Code", 32'(bus.gnt_code), 32'd1);
      tick();
      expectEq("t2Done", 32'(bus.gnt_valid), 32'd0);
      expectEq("t2Pend", 32'(bus.pend_o), 32'h000);
      expectEq("t2Cnt", 32'(bus.gnt_cnt), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         expectEq("t2OnlyOne", 32'(bus.gnt_valid), 32'd0);
      end

      $display("[TB] two requests");
      bus.req_in = 12'h003;
      tick();
      bus.req_in = 12'h000;
      expectEq("t3PendSet", 32'(bus.pend_o), 32'h003);
      tick();
      expectEq("t3Code1", 32'(bus.gnt_code), 32'd1);
      expectEq("t3Valid1", 32'(bus.gnt_valid), 32'd1);
      tick();
      expectEq("t3Code2", 32'(bus.gnt_code), 32'd2);
      expectEq("t3Valid2", 32'(bus.gnt_valid), 32'd1);
      tick();
      expectEq("t3Done", 32'(bus.gnt_valid), 32'd0);
      expectEq("t3Pend", 32'(bus.pend_o), 32'h000);
      expectEq("t3Cnt", 32'(bus.gnt_cnt), 32'd3);

      $display("[TB] backpressure");
      bus.gnt_ready = 1'b0;
      bus.req_in = 12'h003;
      tick();
      bus.req_in = 12'h000;
      tick();
      for (int i = 0; i < 5; i++) begin
         expectEq("t4HoldValid", 32'(bus.gnt_valid), 32'd1);
         expectEq("t4HoldCode", 32'(bus.gnt_code), 32'd1);
         expectEq("t4HoldPend", 32'(bus.pend_o), 32'h003);
         tick();
      end
      bus.gnt_ready = 1'b1;
      tick();
      expectEq("t4PendAfter", 32'(bus.pend_o), 32'h002);
      expectEq("t4Code2", 32'(bus.gnt_code), 32'd2);
      tick();
      expectEq("t4Pend", 32'(bus.pend_o), 32'h000);
      expectEq("t4Cnt", 32'(bus.gnt_cnt), 32'd5);

      $display("[TB] set wins over clear");
      bus.req_in = 12'h001;
      tick();
      bus.req_in = 12'h000;
      tick();
      expectEq("t5Code", 32'(bus.gnt_code), 32'd1);
      bus.req_in = 12'h001;
      tick();
      bus.req_in = 12'h000;
      expectEq("t5PendKept", 32'(bus.pend_o), 32'h001);
      expectEq("t5Idle", 32'(bus.gnt_valid), 32'd0);
      expectEq("t5Cnt1", 32'(bus.gnt_cnt), 32'd6);
      tick();
      expectEq("t5Regrant", 32'(bus.gnt_valid), 32'd1);
      expectEq("t5RegrantCode", 32'(bus.gnt_code), 32'd1);
      tick();
      expectEq("t5Pend", 32'(bus.pend_o), 32'h000);
      expectEq("t5Cnt2", 32'(bus.gnt_cnt), 32'd7);

      $display("[TB] illegal codes");
      forceCodes  = 1'b1;
      forceFirst  = 4'd13;
      forceSecond = 4'd0;
      bus.req_in = 12'h001;
      tick();
      bus.req_in = 12'h000;
      tick();
      expectEq("t6Err", 32'(bus.code_err), 32'd1);
      expectEq("t6NoValid", 32'(bus.gnt_valid), 32'd0);
      expectEq("t6Idle", 32'(bus.busy), 32'd0);
      tick();
      expectEq("t6StillIdle", 32'(bus.gnt_valid), 32'd0);
      expectEq("t6PendHeld", 32'(bus.pend_o), 32'h001);
      forceFirst  = 4'd1;
      forceSecond = 4'd1;
      tick();
      expectEq("t6DupValid", 32'(bus.gnt_valid), 32'd1);
      expectEq("t6DupCode", 32'(bus.gnt_code), 32'd1);
      tick();
      expectEq("t6OneGrant", 32'(bus.gnt_valid), 32'd0);
      expectEq("t6Cnt", 32'(bus.gnt_cnt), 32'd8);
      tick();
      expectEq("t6StillOne", 32'(bus.gnt_valid), 32'd0);
      expectEq("t6Sticky", 32'(bus.code_err), 32'd1);
      forceCodes = 1'b0;

      reset = 1'b1;
      tick();
      reset = 1'b0;
      expectEq("rst2Err", 32'(bus.code_err), 32'd0);
      expectEq("rst2Cnt", 32'(bus.gnt_cnt), 32'd0);

      $display("[TB] randomized traffic");
      modelPend = 12'h000;
      modelCnt  = 8'd0;
      phase     = 0;
      expSecond = 4'd0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic [11:0] reqVec;
         reqVec = 12'h000;
         for (int b = 0; b < 12; b++) begin
            if ($urandom_range(0, 9) == 0) reqVec[b] = 1'b1;
         end
         applyStimulus(reqVec, ($urandom_range(0, 2) != 0));
         checkOutput();
      end
      for (int k = 0; k < 60 && !(bus.pend_o == 12'h000 && !bus.gnt_valid); k++) begin
         applyStimulus(12'h000, 1'b1);
         checkOutput();
      end
      expectEq("drainPend", 32'(bus.pend_o), 32'h000);
      expectEq("drainValid", 32'(bus.gnt_valid), 32'd0);

      $display("[TB] reset during first grant");
      bus.gnt_ready = 1'b0;
      bus.req_in = 12'h005;
      tick();
      bus.req_in = 12'h000;
      tick();
      expectEq("t1Offered", 32'(bus.gnt_valid), 32'd1);
      reset = 1'b1;
      tick();
      expectEq("t1Valid", 32'(bus.gnt_valid), 32'd0);
      expectEq("t1Pend", 32'(bus.pend_o), 32'h000);
      expectEq("t1Cnt", 32'(bus.gnt_cnt), 32'd0);
      expectEq("t1Err", 32'(bus.code_err), 32'd0);
      expectEq("t1Busy", 32'(bus.busy), 32'd0);
      reset = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
